// File: rtl/boolean_flip_selector.sv
// Boolean flip selector: picks one variable index 0..N-1 per request using a
// 16-bit Galois LFSR with rejection sampling and a round-robin fallback.
// Optional macro BOOLEAN_SELECT_EXCLUDE_LAST_EN forbids repeating the last index.
`ifndef NUMBER_OF_BOOLEAN_VARIABLES
`define NUMBER_OF_BOOLEAN_VARIABLES 5
`endif
`ifndef BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX
`define BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX 3
`endif

module boolean_flip_selector #(
    parameter int          LFSR_WIDTH  = 16,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          MAX_RETRIES = 8
) (
    input  logic                                            in_clk,
    input  logic                                            in_reset_n,
    input  logic                                            in_start,
    input  logic                                            in_ready,
    input  logic                                            in_seed_load,
    input  logic [15:0]                                     in_seed,
    output logic [`BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX-1:0] out_index,
    output logic                                            out_valid,
    output logic                                            out_busy,
    output logic                                            out_fallback
);

    localparam int N  = `NUMBER_OF_BOOLEAN_VARIABLES;
    localparam int W  = `BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [LFSR_WIDTH-1:0] TAPS  = LFSR_WIDTH'(16'hB400);
    localparam logic [LFSR_WIDTH-1:0] SEEDV = LFSR_WIDTH'(SEED);

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_step;
    logic [RW-1:0]           retry_q, retry_d;
    logic [W-1:0]            rr_q, rr_d;
    logic [W-1:0]            idx_q, idx_d;
    logic                    fb_q, fb_d;
    logic [W-1:0]            cand;
    logic [W-1:0]            fb_idx;
    logic                    reject;

`ifdef BOOLEAN_SELECT_EXCLUDE_LAST_EN
    // last_q is meaningless until has_last_q is set by the first output
    logic [W-1:0]            last_q, last_d;
    logic                    has_last_q, has_last_d;
    logic                    excl_en;
    assign excl_en = has_last_q && (N > 1);
`endif

    // Round-robin successor, wrapping N-1 -> 0
    function automatic logic [W-1:0] next_idx(input logic [W-1:0] i);
        return (i == W'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    // Next-state, LFSR stepping, candidate accept/reject and fallback selection
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        retry_d   = retry_q;
        rr_d      = rr_q;
        idx_d     = idx_q;
        fb_d      = fb_q;
        lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        cand      = lfsr_step[W-1:0];
        reject    = (int'(cand) >= N);
        fb_idx    = rr_q;
`ifdef BOOLEAN_SELECT_EXCLUDE_LAST_EN
        last_d     = last_q;
        has_last_d = has_last_q;
        if (excl_en && cand == last_q) reject = 1'b1;
        if (excl_en && rr_q == last_q) fb_idx = next_idx(rr_q);
`endif
        case (state_q)
            IDLE: begin
                // a same-edge start draws from the freshly loaded seed
                if (in_seed_load)
                    lfsr_d = (in_seed == 16'h0) ? SEEDV : LFSR_WIDTH'(in_seed);
                if (in_start) begin
                    state_d = DRAW;
                    retry_d = '0;
                end
            end
            DRAW: begin
                lfsr_d = lfsr_step;
                if (int'(retry_q) >= MAX_RETRIES) begin
                    idx_d   = fb_idx;
                    fb_d    = 1'b1;
                    rr_d    = next_idx(fb_idx);
                    state_d = HOLD;
`ifdef BOOLEAN_SELECT_EXCLUDE_LAST_EN
                    last_d     = fb_idx;
                    has_last_d = 1'b1;
`endif
                end else if (!reject) begin
                    idx_d   = cand;
                    fb_d    = 1'b0;
                    state_d = HOLD;
`ifdef BOOLEAN_SELECT_EXCLUDE_LAST_EN
                    last_d     = cand;
                    has_last_d = 1'b1;
`endif
                end else begin
                    retry_d = retry_q + 1'b1;
                end
            end
            HOLD: begin
                if (in_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any pending index
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEEDV;
            retry_q <= '0;
            rr_q    <= '0;
            idx_q   <= '0;
            fb_q    <= 1'b0;
`ifdef BOOLEAN_SELECT_EXCLUDE_LAST_EN
            last_q     <= '0;
            has_last_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            retry_q <= retry_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            fb_q    <= fb_d;
`ifdef BOOLEAN_SELECT_EXCLUDE_LAST_EN
            last_q     <= last_d;
            has_last_q <= has_last_d;
`endif
        end
    end

    assign out_index    = idx_q;
    assign out_valid    = (state_q == HOLD);
    assign out_busy     = (state_q != IDLE);
    assign out_fallback = fb_q & (state_q == HOLD);

endmodule

// File: tb/tb_boolean_flip_selector.sv
// Scoreboarded random bench for boolean_flip_selector with a behavioural model.
`ifndef NUMBER_OF_BOOLEAN_VARIABLES
`define NUMBER_OF_BOOLEAN_VARIABLES 5
`endif
`ifndef BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX
`define BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX 3
`endif

module tb_boolean_flip_selector;

    localparam int N           = `NUMBER_OF_BOOLEAN_VARIABLES;
    localparam int W           = `BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
    localparam int MAX_RETRIES = 8;
    localparam int SEED        = 'hACE1;
`ifdef BOOLEAN_SELECT_EXCLUDE_LAST_EN
    localparam bit EXCL = 1'b1;
`else
    localparam bit EXCL = 1'b0;
`endif

    logic         in_clk = 1'b0;
    logic         in_reset_n = 1'b0;
    logic         in_start = 1'b0;
    logic         in_ready = 1'b0;
    logic         in_seed_load = 1'b0;
    logic [15:0]  in_seed = 16'h0;
    logic [W-1:0] out_index;
    logic         out_valid, out_busy, out_fallback;

    boolean_flip_selector dut (
        .in_clk(in_clk), .in_reset_n(in_reset_n), .in_start(in_start),
        .in_ready(in_ready), .in_seed_load(in_seed_load), .in_seed(in_seed),
        .out_index(out_index), .out_valid(out_valid), .out_busy(out_busy),
        .out_fallback(out_fallback)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {int idx; bit fb;} exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int fails   = 0;

    // model state: generator value, fallback pointer, last output
    int m_lfsr, m_rr, m_last;
    bit m_has;

    task automatic check(input bit ok, input string name, input int act, input int expv);
        vectors++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int lfsr_next(input int l);
        return (l >> 1) ^ (((l & 1) != 0) ? 'hB400 : 0);
    endfunction

    function automatic void model_reset();
        m_lfsr = SEED; m_rr = 0; m_last = 0; m_has = 1'b0;
    endfunction

    // One request: up to MAX_RETRIES rejected draws, then the fallback pointer
    function automatic void model_draw(output int idx, output bit fb, output int cyc);
        int  cand;
        bit  excl;
        idx = 0; fb = 1'b0; cyc = 0;
        for (int k = 0; k <= MAX_RETRIES; k++) begin
            m_lfsr = lfsr_next(m_lfsr);
            cyc++;
            excl = EXCL && m_has && (N > 1);
            if (k == MAX_RETRIES) begin
                idx = m_rr;
                if (excl && idx == m_last) idx = (idx + 1) % N;
                fb = 1'b1;
                m_rr = (idx + 1) % N;
                break;
            end
            cand = m_lfsr % (1 << W);
            if (cand < N && !(excl && cand == m_last)) begin
                idx = cand;
                break;
            end
        end
        m_last = idx; m_has = 1'b1;
    endfunction

    // Seed whose first MAX_RETRIES candidates are all out of range
    function automatic int find_reject_seed();
        int l;
        bit ok;
        for (int s = 1; s < 65536; s++) begin
            l = s; ok = 1'b1;
            for (int k = 0; k < MAX_RETRIES; k++) begin
                l = lfsr_next(l);
                if (l % (1 << W) < N) ok = 1'b0;
            end
            if (ok) return s;
        end
        return 0;
    endfunction

    // Monitor: every new out_valid pulse is matched against the scoreboard
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge in_clk);
            #1;
            if (out_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_valid", int'(out_index), -1);
                end else begin
                    e = exp_q.pop_front();
                    check(int'(out_index) == e.idx, "index", int'(out_index), e.idx);
                    check(out_fallback == e.fb, "fallback_flag", int'(out_fallback), int'(e.fb));
                end
            end
            prev = out_valid;
        end
    end

    task automatic do_reset();
        @(negedge in_clk);
        #2 in_reset_n = 1'b0;
        #1;
        check(!out_valid && !out_busy && !out_fallback && out_index == '0, "reset_outputs",
              {out_valid, out_busy, out_fallback, out_index}, 0);
        exp_q.delete();
        model_reset();
        in_start = 1'b0; in_seed_load = 1'b0; in_ready = 1'b0;
        repeat (2) @(negedge in_clk);
        in_reset_n = 1'b1;
    endtask

    task automatic idle_load(input logic [15:0] sd);
        @(negedge in_clk);
        in_seed_load = 1'b1; in_seed = sd; in_ready = 1'($urandom);
        m_lfsr = (sd == 16'h0) ? SEED : int'(sd);
        @(negedge in_clk);
        in_seed_load = 1'b0; in_ready = 1'b0;
    endtask

    // Issue one request, inject ignored control noise while busy, then hand shake
    task automatic request(input bit ld, input logic [15:0] sd, input int hold_cyc,
                           output int got_idx, output bit got_fb);
        exp_t         e;
        int           ei, cyc, n;
        bit           ef;
        logic [W-1:0] held;
        got_idx = -1; got_fb = 1'b0;
        @(negedge in_clk);
        in_start = 1'b1; in_seed_load = ld; in_seed = sd;
        if (ld) m_lfsr = (sd == 16'h0) ? SEED : int'(sd);
        model_draw(ei, ef, cyc);
        e.idx = ei; e.fb = ef;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge in_clk);
            n++;
            in_start = 1'($urandom); in_seed_load = 1'($urandom);
            in_seed = 16'($urandom); in_ready = 1'($urandom);
        end while (!out_valid && n < 200);
        in_start = 1'b0; in_seed_load = 1'b0; in_ready = 1'b0;
        check(n == cyc + 1, "start_to_valid_edges", n, cyc + 1);
        if (!out_valid) return;
        got_idx = int'(out_index); got_fb = out_fallback; held = out_index;
        repeat (hold_cyc) begin
            @(negedge in_clk);
            check(out_valid && out_busy && out_index == held, "hold_stable", int'(out_index), int'(held));
        end
        in_ready = 1'b1;
        @(negedge in_clk);
        in_ready = 1'b0;
        check(!out_valid && !out_busy, "release_to_idle", {out_valid, out_busy}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          gi, fs, r, bad;
        bit          gf, ld;
        logic [15:0] sd;
        model_reset();
        #3;
        check(!out_valid && !out_busy && !out_fallback && out_index == '0, "reset_outputs",
              {out_valid, out_busy, out_fallback, out_index}, 0);
        repeat (2) @(negedge in_clk);
        in_reset_n = 1'b1;

        // first draw from SEED: E270 -> index 0, long hold
        request(1'b0, 16'h0, 10, gi, gf);
        check(gi == 0 && !gf, "first_draw_index", gi, 0);

        // forced fallback twice from a seed with all-rejected draws
        fs = find_reject_seed();
        check(fs != 0, "reject_seed_found", fs, 1);
        do_reset();
        request(1'b1, 16'(fs), 2, gi, gf);
        check(gi == 0 && gf, "fallback_first", gi * 2 + int'(gf), 1);
        request(1'b1, 16'(fs), 1, gi, gf);
        check(gi == 1 && gf, "fallback_second", gi * 2 + int'(gf), 3);

        // zero seed behaves as SEED
        request(1'b1, 16'h0, 0, gi, gf);
        check(gi == 0 && !gf, "zero_seed_index", gi, 0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) idle_load(16'h0);
            else if (r < 3) idle_load(16'($urandom));
            ld = ($urandom_range(0, 3) == 0);
            sd = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            request(ld, sd, $urandom_range(0, 4), gi, gf);
            repeat ($urandom_range(0, 2)) begin
                @(negedge in_clk);
                in_ready = 1'($urandom);
            end
            in_ready = 1'b0;
        end

        // reset in the middle of a long DRAW
        @(negedge in_clk);
        in_start = 1'b1; in_seed_load = 1'b1; in_seed = 16'(fs);
        @(negedge in_clk);
        in_start = 1'b0; in_seed_load = 1'b0;
        repeat (3) @(negedge in_clk);
        check(out_busy && !out_valid, "busy_in_draw", {out_busy, out_valid}, 2);
        do_reset();
        bad = 0;
        repeat (20) begin
            @(negedge in_clk);
            if (out_valid || out_busy) bad++;
        end
        check(bad == 0, "no_valid_after_reset", bad, 0);
        request(1'b0, 16'h0, 1, gi, gf);
        check(gi == 0 && !gf, "draw_after_reset", gi, 0);

`ifdef BOOLEAN_SELECT_EXCLUDE_LAST_EN
        begin
            int prev_i, seen;
            prev_i = -1; seen = 0;
            for (int i = 0; i < 1000; i++) begin
                ld = ($urandom_range(0, 7) == 0);
                request(ld, 16'($urandom), 0, gi, gf);
                if (prev_i >= 0) check(gi != prev_i, "no_repeat", gi, prev_i);
                if (gi >= 0) seen = seen | (1 << gi);
                prev_i = gi;
            end
            check(seen == (1 << N) - 1, "all_indices_seen", seen, (1 << N) - 1);
        end
`endif

        repeat (3) @(negedge in_clk);
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
